// File: rtl/ysyx_22040038_pkg.sv
// Shared types and default widths for the ysyx_22040038 memory arbiter slice.
package ysyx_22040038_pkg;

    localparam int DEF_ADDR_W  = 64;
    localparam int DEF_DATA_W  = 64;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_e;

    // One-hot grant encodings produced by the round-robin picker
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_IF   = 2'b01;
    localparam logic [1:0] GRANT_LS   = 2'b10;

endpackage

// File: rtl/ysyx_22040038_rr_arb2.sv
// Two-way round-robin picker: one-hot grant from two valids and the previous winner.
module ysyx_22040038_rr_arb2
    import ysyx_22040038_pkg::*;
(
    input  logic       if_valid,
    input  logic       ls_valid,
    input  req_id_e    last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = GRANT_NONE;
        if (if_valid && ls_valid) begin
            // On a tie the side that did not win last time goes first
            grant = (last_grant == REQ_LS) ? GRANT_IF : GRANT_LS;
        end else if (if_valid) begin
            grant = GRANT_IF;
        end else if (ls_valid) begin
            grant = GRANT_LS;
        end
    end

endmodule

// File: rtl/ysyx_22040038_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store: one outstanding
// transaction, round-robin grant, registered request fields and a response watchdog.
module ysyx_22040038_mem_arbiter
    import ysyx_22040038_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rsp_valid,
    output logic                if_rsp_err,

    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic                ls_wen,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_rsp_valid,
    output logic                ls_rsp_err,

    output logic [DATA_W-1:0]   rsp_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int                MASK_W    = DATA_W / 8;
    localparam int                WDOG_W    = $clog2(TIMEOUT + 1);
    // The counter is 0 in the first WAIT_RSP cycle, so TIMEOUT-1 marks the TIMEOUT-th one
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    arb_state_e        state;
    req_id_e           last_grant;
    req_id_e           owner;
    logic [WDOG_W-1:0] wdog;

    logic [1:0] grant;
    logic       accept;
    logic       win_ls;
    logic       in_idle;
    logic       in_wait;
    logic       expire;
    logic       rsp_fire;

    ysyx_22040038_rr_arb2 u_rr_arb2 (
        .if_valid   (if_req_valid),
        .ls_valid   (ls_req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign in_idle = (state == IDLE);
    assign in_wait = (state == WAIT_RSP);
    assign win_ls  = (grant == GRANT_LS);
    assign accept  = in_idle && (grant != GRANT_NONE);

    // Ready is forced low while reset is held so every output reads 0 during reset
    assign if_req_ready = rst && in_idle && (grant == GRANT_IF);
    assign ls_req_ready = rst && in_idle && (grant == GRANT_LS);

    assign expire   = in_wait && (wdog == WDOG_LAST);
    assign rsp_fire = in_wait && (mem_rsp_valid || expire);

    assign if_rsp_valid = rsp_fire && (owner == REQ_IF);
    assign ls_rsp_valid = rsp_fire && (owner == REQ_LS);
    assign if_rsp_err   = if_rsp_valid && !mem_rsp_valid;
    assign ls_rsp_err   = ls_rsp_valid && !mem_rsp_valid;
    assign rsp_rdata    = (in_wait && mem_rsp_valid) ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            last_grant    <= REQ_LS;
            owner         <= REQ_IF;
            wdog          <= '0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner         <= win_ls ? REQ_LS : REQ_IF;
                        last_grant    <= win_ls ? REQ_LS : REQ_IF;
                        mem_addr      <= win_ls ? ls_addr : if_addr;
                        mem_wen       <= win_ls && ls_wen;
                        mem_wdata     <= win_ls ? ls_wdata : '0;
                        mem_wmask     <= win_ls ? ls_wmask : MASK_W'(0);
                        mem_req_valid <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        wdog          <= '0;
                        state         <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (mem_rsp_valid || expire) begin
                        state <= IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
